lfsr_checker: RTL and testbench

- Receive-side companion to the team's maximal-length Fibonacci LFSR generator (N=8, feedback taps 8,6,5,4). It consumes the generator's serial output bit (generator Q[N] per enabled cycle).
- Self-synchronises to the sequence, then predicts each incoming bit and flags mismatches. It maintains a saturating error counter and declares or drops lock.
- Used in the number-game datapath and bench to prove the random source is running and is not stuck.

---
 rtl/lfsr_checker.sv | 173 +++++++++++++++++
 tb/tb_lfsr_checker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for the serial output of a Fibonacci LFSR generator.
// Fills a history register from the incoming stream, verifies the sequence
// against the tap recurrence, then flywheels on its own predictions while
// locked so that each corrupted input bit produces exactly one mismatch.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_HUNT   | filling the history register with N received bits
// S_CHECK  | history loaded, counting consecutive correct predictions
// S_LOCKED | flywheel running, mismatches pulse and count, lock can drop
module lfsr_checker #(
    parameter int         N           = 8,
    parameter logic [1:N] TAPS        = 8'b0001_1101,
    parameter int         LOCK_CNT    = 16,
    parameter int         LOSS_THRESH = 4,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             bit_in,
    input  logic             clear_count,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int RUN_MAX = (LOCK_CNT > N) ? LOCK_CNT : N;
    localparam int FILL_W  = $clog2(N + 1);
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

    // Terminal values are compared against the pre-increment count.
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);
    localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_CNT - 1);
    localparam logic [RUN_W-1:0]  RUN_FLY   = RUN_W'(N - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_THRESH - 1);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_CHECK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:N]         h_q, h_d;
    logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic [RUN_W-1:0]   good_run_q, good_run_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic               pred;
    logic               mismatch;
    logic [1:N]         h_shift;

    assign pred     = ^(h_q & TAPS);
    assign mismatch = bit_in ^ pred;
    assign h_shift  = {bit_in, h_q[1:N-1]};

    // Next-state, history, counters and registered outputs.
    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        fill_cnt_d  = fill_cnt_q;
        good_run_d  = good_run_q;
        miss_cnt_d  = miss_cnt_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;

        if (enable) begin
            case (state_q)
                S_HUNT: begin
                    h_d = h_shift;
                    if (fill_cnt_q == FILL_LAST) begin
                        fill_cnt_d = '0;
                        if (h_shift != '0) begin
                            state_d    = S_CHECK;
                            good_run_d = '0;
                        end
                    end else begin
                        fill_cnt_d = fill_cnt_q + FILL_W'(1);
                    end
                end

                S_CHECK: begin
                    h_d = h_shift;
                    if (h_shift == '0) begin
                        // An all-zero history can never predict a live stream.
                        state_d    = S_HUNT;
                        fill_cnt_d = '0;
                        good_run_d = '0;
                    end else if (mismatch) begin
                        good_run_d = '0;
                    end else if (good_run_q == RUN_LOCK) begin
                        state_d    = S_LOCKED;
                        miss_cnt_d = '0;
                        good_run_d = '0;
                    end else begin
                        good_run_d = good_run_q + RUN_W'(1);
                    end
                end

                S_LOCKED: begin
                    // Shift the prediction, not the input, so one bad bit
                    // does not poison the following predictions.
                    h_d = {pred, h_q[1:N-1]};
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != {CNT_W{1'b1}}) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                        good_run_d = '0;
                        if (miss_cnt_q == MISS_LAST) begin
                            state_d    = S_HUNT;
                            fill_cnt_d = '0;
                            h_d        = '0;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MISS_W'(1);
                        end
                    end else if (good_run_q == RUN_FLY) begin
                        miss_cnt_d = '0;
                        good_run_d = '0;
                    end else begin
                        good_run_d = good_run_q + RUN_W'(1);
                    end
                end

                default: begin
                    state_d    = S_HUNT;
                    fill_cnt_d = '0;
                    h_d        = '0;
                end
            endcase
        end

        if (clear_count) begin
            err_count_d = '0;
        end

        locked_d = (state_d == S_LOCKED);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_HUNT;
            h_q         <= '0;
            fill_cnt_q  <= '0;
            good_run_q  <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            fill_cnt_q  <= fill_cnt_d;
            good_run_q  <= good_run_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker. A driver issues one stimulus per clock
// and pushes the reference model's expected outputs; a monitor pops and
// compares after every active edge. A second instance with a 4-bit counter
// exercises saturation with a reachable number of errors.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        bit_in = 1'b0;
    logic        clear_count = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic        locked_s, err_pulse_s;
    logic [3:0]  err_count_s;

    lfsr_checker dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .bit_in(bit_in),
        .clear_count(clear_count), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count)
    );

    lfsr_checker #(.CNT_W(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .enable(enable), .bit_in(bit_in),
        .clear_count(clear_count), .locked(locked_s), .err_pulse(err_pulse_s),
        .err_count(err_count_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit lk;
        bit ep;
        int cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   pulse_cnt = 0;

    // Generator stream: seed 'd1 emits 1 then seven 0s, then the tap recurrence.
    bit   seq[0:254];
    int   gi = 0;

    // Reference model state (mode: 0 hunt, 1 check, 2 locked).
    int   m_mode, m_fill, m_run, m_miss, m_cnt;
    bit   m_hist[$];

    task automatic check(string name, longint act, longint exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit next_bit();
        bit b;
        b = seq[gi % 255];
        gi++;
        return b;
    endfunction

    function automatic bit hist_zero();
        foreach (m_hist[i]) if (m_hist[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_fill = 0; m_run = 0; m_miss = 0; m_cnt = 0;
        m_hist.delete();
        for (int i = 0; i < 8; i++) m_hist.push_back(1'b0);
    endtask

    task automatic hist_push(bit x);
        m_hist.push_back(x);
        void'(m_hist.pop_front());
    endtask

    task automatic model_step(bit en, bit b, bit clr);
        bit p, pulse;
        exp_t e;
        pulse = 1'b0;
        if (en) begin
            // newest bit at index 7: s_k = s_k-4 ^ s_k-5 ^ s_k-6 ^ s_k-8
            p = m_hist[4] ^ m_hist[3] ^ m_hist[2] ^ m_hist[0];
            case (m_mode)
                0: begin
                    hist_push(b);
                    m_fill++;
                    if (m_fill == 8) begin
                        if (hist_zero()) m_fill = 0;
                        else begin m_mode = 1; m_run = 0; end
                    end
                end
                1: begin
                    hist_push(b);
                    m_run = (b == p) ? m_run + 1 : 0;
                    if (hist_zero()) begin m_mode = 0; m_fill = 0; end
                    else if (m_run == 16) begin m_mode = 2; m_miss = 0; m_run = 0; end
                end
                default: begin
                    hist_push(p);
                    if (b != p) begin
                        pulse = 1'b1; m_cnt++; m_miss++; m_run = 0;
                        if (m_miss == 4) begin
                            m_mode = 0; m_fill = 0;
                            for (int i = 0; i < 8; i++) m_hist[i] = 1'b0;
                        end
                    end else begin
                        m_run++;
                        if (m_run == 8) begin m_run = 0; m_miss = 0; end
                    end
                end
            endcase
        end
        if (clr) m_cnt = 0;
        e.lk = (m_mode == 2);
        e.ep = pulse;
        e.cnt = m_cnt;
        sb_q.push_back(e);
    endtask

    task automatic drive(bit en, bit b, bit clr);
        @(negedge clk);
        enable = en; bit_in = b; clear_count = clr;
        model_step(en, b, clr);
        @(posedge clk);
        #2;
    endtask

    task automatic clean(int n);
        for (int i = 0; i < n; i++) drive(1'b1, next_bit(), 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0; enable = 1'b0; clear_count = 1'b0; bit_in = 1'b0;
        #1;
        check("rst_locked", locked, 0);
        check("rst_err_count", err_count, 0);
        check("rst_err_count_small", err_count_s, 0);
        check("rst_err_pulse", err_pulse, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: compare DUT outputs after each active edge with queued expectations.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("sb_locked", locked, mon_e.lk);
                check("sb_err_pulse", err_pulse, mon_e.ep);
                check("sb_err_count", err_count, sat(mon_e.cnt, 65535));
                check("sb_err_count_small", err_count_s, sat(mon_e.cnt, 15));
                check("sb_locked_small", locked_s, mon_e.lk);
            end
            if (err_pulse) pulse_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        bit b;
        bit en, clr, inj;
        int burst;

        seq[0] = 1'b1;
        for (int k = 1; k < 8; k++) seq[k] = 1'b0;
        for (int k = 8; k < 255; k++) seq[k] = seq[k-4] ^ seq[k-5] ^ seq[k-6] ^ seq[k-8];
        model_reset();

        // Clean lock from seed 1, then one inverted bit at position 30.
        do_reset();
        gi = 0;
        pulse_cnt = 0;
        for (int i = 1; i <= 130; i++) begin
            b = next_bit();
            if (i == 30) b = ~b;
            drive(1'b1, b, 1'b0);
            if (i == 23) check("t1_locked_bit23", locked, 0);
            if (i == 24) check("t1_locked_bit24", locked, 1);
            if (i == 29) begin
                check("t1_err_count", err_count, 0);
                check("t1_no_pulse", pulse_cnt, 0);
            end
            if (i == 30) begin
                check("t2_pulse", err_pulse, 1);
                check("t2_err_count", err_count, 1);
                check("t2_locked", locked, 1);
            end
            if (i == 31) check("t2_pulse_single", err_pulse, 0);
        end
        check("t2_err_count_end", err_count, 1);
        check("t2_pulse_total", pulse_cnt, 1);
        check("t2_locked_end", locked, 1);

        // Stuck-at-zero input never leaves HUNT.
        do_reset();
        for (int i = 0; i < 64; i++) drive(1'b1, 1'b0, 1'b0);
        check("t3_locked", locked, 0);
        check("t3_err_count", err_count, 0);

        // Inverted stream drops lock after four misses; clean stream relocks.
        do_reset();
        gi = 0;
        clean(30);
        pulse_cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, ~next_bit(), 1'b0);
            if (i == 3) check("t4_locked_after3", locked, 1);
        end
        check("t4_locked_after4", locked, 0);
        check("t4_err_count", err_count, 4);
        check("t4_pulses", pulse_cnt, 4);
        for (int i = 1; i <= 24; i++) begin
            drive(1'b1, next_bit(), 1'b0);
            if (i == 23) check("t4_relock_23", locked, 0);
            if (i == 24) check("t4_relock_24", locked, 1);
        end

        // Pre-load five errors, then clear on the same cycle as a mismatch.
        drive(1'b1, next_bit(), 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, ~next_bit(), 1'b0);
        clean(8);
        for (int i = 0; i < 2; i++) drive(1'b1, ~next_bit(), 1'b0);
        check("t5_preload", err_count, 5);
        drive(1'b1, ~next_bit(), 1'b1);
        check("t5_clear_count", err_count, 0);
        check("t5_clear_pulse", err_pulse, 1);
        check("t5_clear_locked", locked, 1);
        clean(8);
        // 21 errors saturate the 4-bit counter without dropping lock.
        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < 3; i++) drive(1'b1, ~next_bit(), 1'b0);
            clean(8);
        end
        check("t5_sat_small", err_count_s, 15);
        check("t5_sat_main", err_count, 21);
        check("t5_sat_locked", locked, 1);

        // Enable low with random bit_in holds everything.
        p0 = pulse_cnt;
        for (int i = 0; i < 10; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        check("t6_hold_locked", locked, 1);
        check("t6_hold_count", err_count, 21);
        check("t6_hold_pulses", pulse_cnt, p0);
        clean(20);
        check("t6_resume_locked", locked, 1);
        check("t6_resume_pulses", pulse_cnt, p0);
        do_reset();

        // Randomised traffic: gaps, injected errors, bursts and clears.
        gi = $urandom_range(0, 254);
        burst = 0;
        for (int i = 0; i < 1200; i++) begin
            en  = ($urandom_range(0, 99) < 85);
            clr = ($urandom_range(0, 99) < 3);
            if (burst == 0 && $urandom_range(0, 99) < 2) burst = $urandom_range(3, 6);
            inj = (burst > 0) || ($urandom_range(0, 99) < 4);
            if (en) begin
                b = next_bit() ^ inj;
                if (burst > 0) burst--;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            drive(en, b, clr);
        end

        @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
